vga_timing_controller: RTL and testbench
========================================

// Module: vga_timing_controller
// PURPOSE
// Generates 640x480@60Hz VGA raster timing from the 50 MHz system clock.
// Produces the pixelx/pixely scan coordinates consumed by the renderer stage.
// Also produces active-low hsync/vsync, the DAC pixel clock, and per-line/per-frame strobes.
// Game logic uses the strobes to pace animation and countdowns.
// PARAMETERS
// CLK_DIV    2    system clocks per pixel (>=2); 50 MHz / 2 = 25 MHz pixel rate
// H_VISIBLE  640  visible pixels per line
// H_FRONT    16   horizontal front porch (pixels)
// H_SYNC     96   horizontal sync width (pixels)
// H_BACK     48   horizontal back porch (pixels); H_TOTAL = 800
// V_VISIBLE  480  visible lines per frame
// V_FRONT    10   vertical front porch (lines)
// V_SYNC     2    vertical sync width (lines)
// V_BACK     33   vertical back porch (lines); V_TOTAL = 525
// PORTS
// clk         in   1   system clock, 50 MHz
// rst         in   1   asynchronous reset, active-low
// pixelx      out  10  horizontal counter, 0..H_TOTAL-1
// pixely      out  10  vertical counter, 0..V_TOTAL-1
// hsync       out  1   horizontal sync, active-low
// vsync       out  1   vertical sync, active-low
// vga_clk     out  1   pixel clock to the DAC
// video_on    out  1   1 when pixelx<H_VISIBLE && pixely<V_VISIBLE
// line_tick   out  1   one-clk pulse when pixelx wraps to 0
// frame_tick  out  1   one-clk pulse when (pixelx,pixely) wraps to (0,0)
// frame_count out  8   frames since reset; wraps 255->0
// BEHAVIOUR
// - Reset (rst=0, async): div_cnt=0, pixelx=0, pixely=0, frame_count=0.
//   Reset also forces hsync=1, vsync=1, vga_clk=0, line_tick=0, frame_tick=0; video_on=1 follows (0,0).
// - Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//   pix_en=1 in the cycle where div_cnt==CLK_DIV-1.
//   vga_clk=1 when div_cnt>=CLK_DIV/2, registered; the rising DAC edge falls mid-pixel.
// - On a clk edge with pix_en: pixelx increments.
//   If pixelx==H_TOTAL-1: pixelx<=0, line_tick<=1, and pixely advances (wraps at V_TOTAL-1 -> 0).
//   If the wrap is also pixely==V_TOTAL-1: pixely<=0, frame_tick<=1, frame_count<=frame_count+1 (mod 256).
// - line_tick and frame_tick are high exactly one clk, in the same cycle the new (0,y)/(0,0) first appears.
// - When pix_en=0, counters hold and ticks are 0.
// - hsync and vsync are registered from the next-state counters, so they align with pixelx/pixely (zero skew).
//   hsync=0 iff pixelx in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
//   vsync=0 iff pixely in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491].
// - video_on is combinational from the registered counters.
// - Latency: coordinate change to the visible outputs is 0 clk. The renderer adds its own pipeline.
// - Reset mid-frame: counters return to (0,0) asynchronously.
//   The first frame_tick after reset occurs after a full H_TOTAL*V_TOTAL*CLK_DIV = 840000 clks.
// - Counter widths are 10 bits. Comparisons use H_TOTAL/V_TOTAL derived localparams. No counter ever exceeds TOTAL-1.
// STRUCTURE
// - vga_pkg: H_* and V_* timing constants, H_TOTAL and V_TOTAL, SCREEN_W=640, SCREEN_H=480.
//   renderer and sprite blocks share this package.
// - Sub-module pixel_clk_div: owns div_cnt, pix_en and vga_clk, parameterised by CLK_DIV.
// - Top level: h/v counter always_ff, sync/tick registers, frame_count.
// TESTING
// - Reset: hold rst=0 for 5 clk -> pixelx=0, pixely=0, hsync=1, vsync=1, ticks=0, frame_count=0.
// - Pixel rate: CLK_DIV=2 -> pixelx steps 0,0,1,1,2,...; vga_clk period is 2 clk with 50% duty.
// - Line timing: hsync falls when pixelx becomes 656 and rises at 752.
//   line_tick pulses every 1600 clk, exactly 1 clk wide, with pixelx=0.
// - Frame timing: vsync low only for pixely 490..491 (3200 clk).
//   frame_tick every 840000 clk; frame_count=3 after three frames.
// - Async reset mid-line at pixelx=400, pixely=200 -> counters are 0 before the next clk edge.
//   The subsequent frame_tick comes 840000 clk after release.
// - video_on: 1 at (639,479), 0 at (640,479) and at (0,480); frame_count wraps 255->0 on the 256th frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz raster constants and helpers used by the timing,
// renderer and sprite blocks.
package vga_pkg;

   localparam int CLK_DIV   = 2;
   localparam int COORD_W   = 10;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;

   // True when a coordinate lies inside the closed window [lo, hi].
   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/pixel_clk_div.sv
// Divides the system clock down to the pixel rate: a one-cycle pix_en per
// pixel and a registered DAC clock whose rising edge lands mid-pixel.
module pixel_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en,
   output logic vga_clk
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_next;

   assign pix_en = (div_cnt == DIV_LAST);

   // Next divider count: wraps to zero after the last system clock of a pixel.
   always_comb begin
      div_next = div_cnt;
      if (div_cnt == DIV_LAST) begin
         div_next = {DW{1'b0}};
      end else begin
         div_next = div_cnt + DW'(1);
      end
   end

   // Divider state and DAC clock, both taken from the next count so they stay aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= {DW{1'b0}};
         vga_clk <= 1'b0;
      end else begin
         div_cnt <= div_next;
         vga_clk <= (div_next >= DIV_HALF);
      end
   end

endmodule

// File: rtl/vga_timing_controller.sv
// Raster timing generator: pixel/line counters, active-low syncs aligned with
// the counters, line/frame strobes and a free-running frame counter.
module vga_timing_controller #(
   parameter int CLK_DIV   = vga_pkg::CLK_DIV,
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] pixelx,
   output logic [9:0] pixely,
   output logic       hsync,
   output logic       vsync,
   output logic       vga_clk,
   output logic       video_on,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic       pix_en;
   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       line_wrap;
   logic       frame_wrap;

   pixel_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_clk_div (
      .clk     (clk),
      .rst     (rst),
      .pix_en  (pix_en),
      .vga_clk (vga_clk)
   );

   assign video_on = (pixelx < H_VIS) && (pixely < V_VIS);

   // Next raster position; counters only move on pixel-enable cycles.
   always_comb begin
      x_next     = pixelx;
      y_next     = pixely;
      line_wrap  = 1'b0;
      frame_wrap = 1'b0;
      if (pix_en) begin
         if (pixelx == H_LAST) begin
            x_next    = 10'd0;
            line_wrap = 1'b1;
            if (pixely == V_LAST) begin
               y_next     = 10'd0;
               frame_wrap = 1'b1;
            end else begin
               y_next = pixely + 10'd1;
            end
         end else begin
            x_next = pixelx + 10'd1;
         end
      end else begin
         x_next = pixelx;
      end
   end

   // Counters, strobes and syncs; syncs decode the next position so they change with the counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixelx      <= 10'd0;
         pixely      <= 10'd0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         line_tick   <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         pixelx     <= x_next;
         pixely     <= y_next;
         line_tick  <= line_wrap;
         frame_tick <= frame_wrap;
         hsync      <= ~vga_pkg::in_window(x_next, HS_LO, HS_HI);
         vsync      <= ~vga_pkg::in_window(y_next, VS_LO, VS_HI);
         if (frame_wrap) begin
            frame_count <= frame_count + 8'd1;
         end else begin
            frame_count <= frame_count;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a full-size instance and a shrunken-raster
// instance share clock and reset; both are compared every cycle against a
// model that derives the raster from the number of clocks since reset.
module tb_vga_timing_controller;

   // Shrunken raster for the second instance: 15 pixels x 8 lines, 240 clk per frame.
   localparam int B_DIV = 2;
   localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
   localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [9:0] a_pixelx, a_pixely, b_pixelx, b_pixely;
   logic       a_hsync, a_vsync, a_vga_clk, a_video_on, a_line_tick, a_frame_tick;
   logic       b_hsync, b_vsync, b_vga_clk, b_video_on, b_line_tick, b_frame_tick;
   logic [7:0] a_frame_count, b_frame_count;

   int checks = 0;
   int errors = 0;
   int k = 0;      // system clock edges since reset release

   typedef struct {
      int x, y, hs, vs, vc, von, lt, ft, fc;
   } exp_t;

   vga_timing_controller dut_a (
      .clk(clk), .rst(rst), .pixelx(a_pixelx), .pixely(a_pixely),
      .hsync(a_hsync), .vsync(a_vsync), .vga_clk(a_vga_clk), .video_on(a_video_on),
      .line_tick(a_line_tick), .frame_tick(a_frame_tick), .frame_count(a_frame_count)
   );

   vga_timing_controller #(
      .CLK_DIV(B_DIV), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
      .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
   ) dut_b (
      .clk(clk), .rst(rst), .pixelx(b_pixelx), .pixely(b_pixely),
      .hsync(b_hsync), .vsync(b_vsync), .vga_clk(b_vga_clk), .video_on(b_video_on),
      .line_tick(b_line_tick), .frame_tick(b_frame_tick), .frame_count(b_frame_count)
   );

   always #5 clk = ~clk;

   // Elapsed-time counter that the model is evaluated from.
   always @(posedge clk or negedge rst) begin
      if (!rst) k <= 0;
      else      k <= k + 1;
   end

   // Raster state after c clock edges: pixel index = c / div, then plain div/mod.
   function automatic exp_t model(int c, int d, int hv, int hf, int hs, int hb,
                                  int vv, int vf, int vs, int vb);
      exp_t e;
      int ht, vt, n;
      ht = hv + hf + hs + hb;
      vt = vv + vf + vs + vb;
      n  = c / d;
      e.x   = n % ht;
      e.y   = (n / ht) % vt;
      e.fc  = (n / (ht * vt)) % 256;
      e.hs  = (e.x >= hv + hf && e.x < hv + hf + hs) ? 0 : 1;
      e.vs  = (e.y >= vv + vf && e.y < vv + vf + vs) ? 0 : 1;
      e.von = (e.x < hv && e.y < vv) ? 1 : 0;
      e.vc  = ((c % d) >= d / 2) ? 1 : 0;
      e.lt  = (c > 0 && (c % d) == 0 && e.x == 0) ? 1 : 0;
      e.ft  = (e.lt == 1 && e.y == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic check1(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at t=%0t k=%0d: got %0d expected %0d", name, $time, k, act, exp);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      exp_t e;
      e = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      check1("a_pixelx", int'(a_pixelx), e.x);
      check1("a_pixely", int'(a_pixely), e.y);
      check1("a_hsync", int'(a_hsync), e.hs);
      check1("a_vsync", int'(a_vsync), e.vs);
      check1("a_vga_clk", int'(a_vga_clk), e.vc);
      check1("a_video_on", int'(a_video_on), e.von);
      check1("a_line_tick", int'(a_line_tick), e.lt);
      check1("a_frame_tick", int'(a_frame_tick), e.ft);
      check1("a_frame_count", int'(a_frame_count), e.fc);
      e = model(k, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB);
      check1("b_pixelx", int'(b_pixelx), e.x);
      check1("b_pixely", int'(b_pixely), e.y);
      check1("b_hsync", int'(b_hsync), e.hs);
      check1("b_vsync", int'(b_vsync), e.vs);
      check1("b_vga_clk", int'(b_vga_clk), e.vc);
      check1("b_video_on", int'(b_video_on), e.von);
      check1("b_line_tick", int'(b_line_tick), e.lt);
      check1("b_frame_tick", int'(b_frame_tick), e.ft);
      check1("b_frame_count", int'(b_frame_count), e.fc);
   end

   task automatic wait_to(input int target);
      int g;
      g = 0;
      while (k != target && g < 100000) begin
         @(negedge clk);
         g++;
      end
      check1("reach_k", k, target);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int cnt;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check1("rst_pixelx", int'(a_pixelx), 0);
      check1("rst_pixely", int'(a_pixely), 0);
      check1("rst_hsync", int'(a_hsync), 1);
      check1("rst_vsync", int'(a_vsync), 1);
      check1("rst_ticks", int'(a_line_tick | a_frame_tick | b_line_tick | b_frame_tick), 0);
      check1("rst_fcount", int'(a_frame_count), 0);
      check1("rst_vga_clk", int'(a_vga_clk), 0);
      check1("rst_video_on", int'(a_video_on), 1);
      release_rst();

      // Hand-computed pins of the timeline after release.
      wait_to(1);     check1("vga_clk_hi", int'(a_vga_clk), 1);
                      check1("px_step0", int'(a_pixelx), 0);
      wait_to(2);     check1("vga_clk_lo", int'(a_vga_clk), 0);
                      check1("px_step1", int'(a_pixelx), 1);
      wait_to(104);   check1("b_von_7_3", int'(b_video_on), 1);
      wait_to(106);   check1("b_von_8_3", int'(b_video_on), 0);
      wait_to(120);   check1("b_von_0_4", int'(b_video_on), 0);
                      check1("b_py_4", int'(b_pixely), 4);
      wait_to(719);   check1("b_fc_2", int'(b_frame_count), 2);
      wait_to(720);   check1("b_fc_3", int'(b_frame_count), 3);
                      check1("b_ft_3", int'(b_frame_tick), 1);
      wait_to(1278);  check1("a_von_639", int'(a_video_on), 1);
                      check1("a_px_639", int'(a_pixelx), 639);
      wait_to(1280);  check1("a_von_640", int'(a_video_on), 0);
      wait_to(1311);  check1("a_hs_655", int'(a_hsync), 1);
      wait_to(1312);  check1("a_hs_656", int'(a_hsync), 0);
                      check1("a_px_656", int'(a_pixelx), 656);
      wait_to(1502);  check1("a_hs_751", int'(a_hsync), 0);
      wait_to(1504);  check1("a_hs_752", int'(a_hsync), 1);
      wait_to(1600);  check1("a_lt_1600", int'(a_line_tick), 1);
                      check1("a_lt_px0", int'(a_pixelx), 0);
                      check1("a_lt_py1", int'(a_pixely), 1);
      wait_to(1601);  check1("a_lt_width", int'(a_line_tick), 0);
      wait_to(3200);  check1("a_lt_3200", int'(a_line_tick), 1);
      wait_to(61200); check1("b_fc_255", int'(b_frame_count), 255);
      wait_to(61440); check1("b_fc_wrap", int'(b_frame_count), 0);
                      check1("b_ft_wrap", int'(b_frame_tick), 1);

      // Async reset in mid-line at pixelx=400; counters must clear before the next edge.
      cnt = 0;
      while (a_pixelx != 10'd400 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check1("find_px400", int'(a_pixelx), 400);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check1("mid_rst_px", int'(a_pixelx), 0);
      check1("mid_rst_py", int'(a_pixely), 0);
      check1("mid_rst_hs", int'(a_hsync), 1);
      check1("mid_rst_bpx", int'(b_pixelx), 0);
      repeat (3) @(negedge clk);
      release_rst();
      cnt = 0;
      while (b_frame_tick != 1'b1 && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      check1("b_ft_after_rst", cnt, 240);

      // Randomised reset pulses; the per-cycle model keeps checking throughout.
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(50, 3000)) @(negedge clk);
         @(posedge clk);
         #($urandom_range(1, 4)) rst = 1'b0;
         #0.5;
         check1("rnd_rst_px", int'(a_pixelx), 0);
         repeat ($urandom_range(1, 6)) @(negedge clk);
         release_rst();
      end
      repeat (500) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
